bullet_scheduler: RTL and testbench
===================================

BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 Parameter TANK_NUM, default 2, number of tanks / fire requesters.
REQ-002 Parameter ARRAY_SIZE, default 8, bullet slots per tank.
REQ-003 Parameter SPEED, default 2, pixels moved per axis per frame.
REQ-004 Parameter TTL_INIT, default 31, frames a bullet lives, 5-bit.
REQ-005 Port CLK  input  1  system clock; the block SHALL use one clock only.
REQ-006 Port Reset_n  input  1  reset; the block SHALL treat it as asynchronous and active-low.
REQ-007 Port frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-008 Port fire_req  input  [TANK_NUM]  per-tank fire request, level, held until acked.
REQ-009 Port tank_x, tank_y  input  [TANK_NUM] x 10  tank top-left position.
REQ-010 Port turret_dir  input  [TANK_NUM] x 3  turret direction (0=N,1=NE,2=E,3=SE,4=S,5=SW,6=W,7=NW).
REQ-011 Port fire_ack  output  [TANK_NUM]  one-cycle pulse when a request is consumed.
REQ-012 Port fire_drop  output  [TANK_NUM]  one-cycle pulse with fire_ack when no free slot existed.
REQ-013 Port bullet_array  output  [TANK_NUM][ARRAY_SIZE] x 32  bullet table, registered, read by the drawing engine.
REQ-014 Port busy  output  1  high while the frame update sweep runs.

Function
REQ-015 Bullet word SHALL be: [0] valid, [3:1] dir, [8:4] ttl, [18:9] X centre, [28:19] Y centre, [31:29] zero.
REQ-016 FSM SHALL have states IDLE, UPDATE, FIRE; reset state IDLE.
REQ-017 IDLE: frame_start=1 -> UPDATE with slot index 0, taking priority over any pending fire_req.
REQ-018 IDLE: no frame_start and any fire_req=1 -> FIRE.
REQ-019 UPDATE SHALL process one slot per cycle, tank-major (tank0 slots 0..7, then tank1 slots 0..7), 16 cycles total, then -> IDLE; busy=1 in all UPDATE cycles.
REQ-020 Per valid slot: X += dx*SPEED, Y += dy*SPEED, with dx,dy in {-1,0,+1} from dir (N: dy=-1; E: dx=+1); arithmetic SHALL be 11-bit signed.
REQ-021 Slot SHALL be cleared to 0 if new X<0 or X>639, new Y<0 or Y>479, or ttl==1 before decrement; otherwise ttl SHALL decrement by 1.
REQ-022 Invalid slots SHALL be untouched by UPDATE.
REQ-023 frame_start during UPDATE or FIRE SHALL be ignored (no queueing).
REQ-024 FIRE SHALL take one cycle: grant one tank, write at most one slot, pulse fire_ack for that tank, -> IDLE.
REQ-025 Arbitration: single requester wins; both requesting -> round-robin pointer decides, and the pointer SHALL flip to the other tank after each grant; pointer resets to tank 0.
REQ-026 Granted tank's lowest-index invalid slot SHALL be written with valid=1, dir=turret_dir, ttl=TTL_INIT, X=tank_x+16, Y=tank_y+16 (10-bit truncated).
REQ-027 No invalid slot for granted tank -> table unchanged, fire_ack and fire_drop both pulse.
REQ-028 A requester SHALL see at most one ack per request; fire_req still high the cycle after ack is a new request (FIRE reachable no sooner than 2 cycles later via IDLE).
REQ-029 A tank's slots SHALL never be written by the other tank's grant.

Reset
REQ-030 Reset_n=0 SHALL immediately clear all bullet_array words, fire_ack, fire_drop, busy, and the RR pointer, and force IDLE, including mid-UPDATE or mid-FIRE.
REQ-031 After Reset_n deasserts, the first frame_start or fire_req SHALL be acted on normally from IDLE.

Verification
REQ-032 Fire: tank0 at (100,200), dir=2, fire_req[0]=1 -> fire_ack[0] within 2 cycles; slot[0][0] = valid, dir 2, ttl 31, X=116, Y=216.
REQ-033 Move: after REQ-032, one frame_start -> busy 16 cycles; slot[0][0] X=118, Y=216, ttl=30.
REQ-034 Edge: bullet X=638 dir=2 at frame_start -> slot cleared to 0; bullet with ttl=1 -> cleared after update.
REQ-035 Full: 8 fires from tank1 fill slots [1][0..7]; 9th fire -> fire_ack[1] and fire_drop[1] pulse, table unchanged.
REQ-036 Arbitration: both fire_req high continuously -> grants alternate 0,1,0,1; frame_start same cycle as fire_req in IDLE -> UPDATE first, fire serviced after busy falls.
REQ-037 Reset mid-UPDATE at slot 5 -> all words 0, busy 0 in same cycle, state IDLE.

Source files
------------

// File: rtl/bullet_scheduler.sv
// bullet_scheduler: per-tank bullet table with fire arbitration and a
// one-slot-per-cycle frame update sweep (move, bounds check, ttl ageing).
module bullet_scheduler #(
   parameter int         TANK_NUM   = 2,
   parameter int         ARRAY_SIZE = 8,
   parameter int         SPEED      = 2,
   parameter logic [4:0] TTL_INIT   = 5'd31
) (
   input  logic                                      CLK,
   input  logic                                      Reset_n,
   input  logic                                      frame_start,
   input  logic [TANK_NUM-1:0]                       fire_req,
   input  logic [TANK_NUM-1:0][9:0]                  tank_x,
   input  logic [TANK_NUM-1:0][9:0]                  tank_y,
   input  logic [TANK_NUM-1:0][2:0]                  turret_dir,
   output logic [TANK_NUM-1:0]                       fire_ack,
   output logic [TANK_NUM-1:0]                       fire_drop,
   output logic [TANK_NUM-1:0][ARRAY_SIZE-1:0][31:0] bullet_array,
   output logic                                      busy
);
   localparam int TW = TANK_NUM > 1 ? $clog2(TANK_NUM) : 1;
   localparam int SW = ARRAY_SIZE > 1 ? $clog2(ARRAY_SIZE) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(ARRAY_SIZE - 1);
   localparam logic [TW-1:0] TANK_LAST = TW'(TANK_NUM - 1);
   localparam logic signed [10:0] STEP = 11'(SPEED);

   typedef enum logic [1:0] {IDLE, UPDATE, FIRE} state_t;

   state_t                                     state_q, state_d;
   logic [TW-1:0]                              tank_q, tank_d, ptr_q, ptr_d, gnt;
   logic [SW-1:0]                              slot_q, slot_d, free_s;
   logic [TANK_NUM-1:0][ARRAY_SIZE-1:0][31:0]  bullet_q, bullet_d;
   logic [TANK_NUM-1:0]                        rq;
   logic [TW:0]                                off, sum, nxt;
   logic                                       gnt_v, free_v, kill;
   logic [28:0]                                cur;
   logic [2:0]                                 dir;
   logic signed [10:0]                         x0, y0, nx, ny;

   assign cur  = bullet_q[tank_q][slot_q][28:0];
   assign dir  = cur[3:1];
   assign x0   = $signed({1'b0, cur[18:9]});
   assign y0   = $signed({1'b0, cur[28:19]});
   assign nx   = dir inside {3'd1, 3'd2, 3'd3} ? x0 + STEP : dir inside {3'd5, 3'd6, 3'd7} ? x0 - STEP : x0;
   assign ny   = dir inside {3'd3, 3'd4, 3'd5} ? y0 + STEP : dir inside {3'd0, 3'd1, 3'd7} ? y0 - STEP : y0;
   assign kill = nx < 0 || nx > 11'sd639 || ny < 0 || ny > 11'sd479 || cur[8:4] == 5'd1;

   // Requests rotated so bit 0 is the tank the round-robin pointer favours
   assign rq    = TANK_NUM'({fire_req, fire_req} >> ptr_q);
   assign gnt_v = |fire_req;
   assign sum   = {1'b0, ptr_q} + off;
   assign gnt   = sum >= (TW+1)'(TANK_NUM) ? TW'(sum - (TW+1)'(TANK_NUM)) : TW'(sum);
   assign nxt   = {1'b0, gnt} + 1'b1;

   always_comb begin
      off = '0;
      for (int i = TANK_NUM - 1; i >= 0; i--)
         if (rq[i]) off = (TW+1)'(i);
   end

   always_comb begin
      free_v = 1'b0;
      free_s = '0;
      for (int s = ARRAY_SIZE - 1; s >= 0; s--)
         if (!bullet_q[gnt][s][0]) begin
            free_v = 1'b1;
            free_s = SW'(s);
         end
   end

   always_comb begin
      state_d   = state_q;
      tank_d    = tank_q;
      slot_d    = slot_q;
      ptr_d     = ptr_q;
      bullet_d  = bullet_q;
      fire_ack  = '0;
      fire_drop = '0;
      unique case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = UPDATE;
               tank_d  = '0;
               slot_d  = '0;
            end else if (gnt_v) state_d = FIRE;
         end
         UPDATE: begin
            if (cur[0])
               bullet_d[tank_q][slot_q] = kill ? 32'd0 :
                  {3'b000, ny[9:0], nx[9:0], cur[8:4] - 5'd1, dir, 1'b1};
            slot_d = slot_q == SLOT_LAST ? '0 : slot_q + 1'b1;
            tank_d = slot_q != SLOT_LAST ? tank_q : tank_q == TANK_LAST ? '0 : tank_q + 1'b1;
            if (slot_q == SLOT_LAST && tank_q == TANK_LAST) state_d = IDLE;
         end
         FIRE: begin
            state_d = IDLE;
            if (gnt_v) begin
               fire_ack[gnt]  = 1'b1;
               fire_drop[gnt] = !free_v;
               ptr_d          = nxt == (TW+1)'(TANK_NUM) ? '0 : TW'(nxt);
               if (free_v)
                  bullet_d[gnt][free_s] = {3'b000, tank_y[gnt] + 10'd16, tank_x[gnt] + 10'd16,
                                           TTL_INIT, turret_dir[gnt], 1'b1};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         tank_q   <= '0;
         slot_q   <= '0;
         ptr_q    <= '0;
         bullet_q <= '0;
      end else begin
         state_q  <= state_d;
         tank_q   <= tank_d;
         slot_q   <= slot_d;
         ptr_q    <= ptr_d;
         bullet_q <= bullet_d;
      end
   end

   assign busy         = state_q == UPDATE;
   assign bullet_array = bullet_q;
endmodule

// File: tb/tb_bullet_scheduler.sv
// tb_bullet_scheduler: directed checks of firing, movement, clipping,
// table-full drops, arbitration and asynchronous reset.
module tb_bullet_scheduler;
   logic                  CLK = 1'b0;
   logic                  Reset_n;
   logic                  frame_start;
   logic [1:0]            fire_req;
   logic [1:0][9:0]       tank_x, tank_y;
   logic [1:0][2:0]       turret_dir;
   logic [1:0]            fire_ack, fire_drop;
   logic [1:0][7:0][31:0] bullet_array;
   logic                  busy;
   int                    total = 0, bad = 0, n;
   logic [1:0]            acc;
   logic [31:0]           w0, w7;

   bullet_scheduler dut (
      .CLK(CLK), .Reset_n(Reset_n), .frame_start(frame_start), .fire_req(fire_req),
      .tank_x(tank_x), .tank_y(tank_y), .turret_dir(turret_dir),
      .fire_ack(fire_ack), .fire_drop(fire_drop), .bullet_array(bullet_array), .busy(busy)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mk(input logic [2:0] d, input logic [4:0] ttl,
                                      input logic [9:0] x, input logic [9:0] y);
      return {3'b000, y, x, ttl, d, 1'b1};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      Reset_n = 1'b0;
      #4;
      Reset_n = 1'b1;
      tick;
   endtask

   task automatic fire(input string tag, input logic t, input logic [9:0] x, input logic [9:0] y,
                       input logic [2:0] d, input logic exp_drop);
      int k;
      tank_x[t] = x;
      tank_y[t] = y;
      turret_dir[t] = d;
      fire_req[t] = 1'b1;
      k = 0;
      do begin
         tick;
         k++;
      end while (!fire_ack[t] && k < 4);
      chk({tag, "_ack"}, {31'b0, fire_ack[t]}, 32'd1);
      chk({tag, "_drop"}, {31'b0, fire_drop[t]}, {31'b0, exp_drop});
      tick;
      fire_req[t] = 1'b0;
   endtask

   task automatic frame(input logic extra, output int cnt);
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      cnt = 0;
      while (busy && cnt < 40) begin
         cnt++;
         frame_start = extra && cnt == 5;
         tick;
      end
      frame_start = 1'b0;
   endtask

   initial begin
      Reset_n = 1'b0;
      frame_start = 1'b0;
      fire_req = '0;
      tank_x = '0;
      tank_y = '0;
      turret_dir = '0;
      #3;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_ack", {30'b0, fire_ack}, 32'd0);
      chk("rst_tbl", {31'b0, |bullet_array}, 32'd0);
      #9;
      Reset_n = 1'b1;
      tick;

      fire("fire0", 1'b0, 10'd100, 10'd200, 3'd2, 1'b0);
      chk("fire0_slot", bullet_array[0][0], mk(3'd2, 5'd31, 10'd116, 10'd216));

      frame(1'b1, n);
      chk("move_busy_cycles", n, 32'd16);
      chk("move_slot", bullet_array[0][0], mk(3'd2, 5'd30, 10'd118, 10'd216));
      tick;
      chk("no_requeue", {31'b0, busy}, 32'd0);

      fire("edge", 1'b0, 10'd622, 10'd100, 3'd2, 1'b0);
      chk("edge_slot", bullet_array[0][1], mk(3'd2, 5'd31, 10'd638, 10'd116));
      frame(1'b0, n);
      chk("edge_clear", bullet_array[0][1], 32'd0);
      chk("edge_other", bullet_array[0][0], mk(3'd2, 5'd29, 10'd120, 10'd216));
      repeat (28) frame(1'b0, n);
      chk("ttl_one", bullet_array[0][0], mk(3'd2, 5'd1, 10'd176, 10'd216));
      frame(1'b0, n);
      chk("ttl_clear", bullet_array[0][0], 32'd0);

      fire("nw", 1'b1, 10'd200, 10'd300, 3'd7, 1'b0);
      chk("nw_slot", bullet_array[1][0], mk(3'd7, 5'd31, 10'd216, 10'd316));
      fire("north", 1'b1, 10'd50, 10'd1009, 3'd0, 1'b0);
      chk("north_trunc", bullet_array[1][1], mk(3'd0, 5'd31, 10'd66, 10'd1));
      frame(1'b0, n);
      chk("nw_move", bullet_array[1][0], mk(3'd7, 5'd30, 10'd214, 10'd314));
      chk("north_clear", bullet_array[1][1], 32'd0);

      do_reset;
      for (int k = 0; k < 8; k++) begin
         fire($sformatf("full%0d", k), 1'b1, 10'(10 * k), 10'd20, 3'(k), 1'b0);
         chk($sformatf("full%0d_slot", k), bullet_array[1][k], mk(3'(k), 5'd31, 10'(10 * k + 16), 10'd36));
      end
      w0 = bullet_array[1][0];
      w7 = bullet_array[1][7];
      fire("drop", 1'b1, 10'd500, 10'd500, 3'd3, 1'b1);
      chk("drop_s0", bullet_array[1][0], w0);
      chk("drop_s7", bullet_array[1][7], w7);
      chk("drop_tank0", {31'b0, |bullet_array[0]}, 32'd0);

      do_reset;
      tank_x = {10'd300, 10'd0};
      tank_y = {10'd400, 10'd0};
      turret_dir = {3'd6, 3'd4};
      fire_req = 2'b11;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         do begin
            tick;
            n++;
         end while (fire_ack == 2'b00 && n < 5);
         chk($sformatf("arb%0d", g), {30'b0, fire_ack}, (g % 2) != 0 ? 32'd2 : 32'd1);
      end
      tick;
      fire_req = 2'b00;
      chk("arb_t0", bullet_array[0][1], mk(3'd4, 5'd31, 10'd16, 10'd16));
      chk("arb_t1", bullet_array[1][1], mk(3'd6, 5'd31, 10'd316, 10'd416));

      fire_req = 2'b01;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      chk("prio_busy", {31'b0, busy}, 32'd1);
      acc = fire_ack;
      n = 1;
      while (busy && n < 40) begin
         tick;
         n++;
         acc = acc | fire_ack;
      end
      chk("prio_cycles", n, 32'd17);
      chk("prio_no_ack", {30'b0, acc}, 32'd0);
      n = 0;
      do begin
         tick;
         n++;
      end while (!fire_ack[0] && n < 4);
      chk("prio_ack_lat", n, 32'd1);
      tick;
      fire_req = 2'b00;
      chk("prio_slot", bullet_array[0][2], mk(3'd4, 5'd31, 10'd16, 10'd16));

      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      repeat (5) tick;
      chk("mid_busy", {31'b0, busy}, 32'd1);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_tbl", {31'b0, |bullet_array}, 32'd0);
      chk("mid_rst_ack", {30'b0, fire_ack}, 32'd0);
      #4;
      Reset_n = 1'b1;
      tick;
      fire("post", 1'b1, 10'd100, 10'd100, 3'd1, 1'b0);
      chk("post_slot", bullet_array[1][0], mk(3'd1, 5'd31, 10'd116, 10'd116));
      frame(1'b0, n);
      chk("post_cycles", n, 32'd16);
      chk("post_move", bullet_array[1][0], mk(3'd1, 5'd30, 10'd118, 10'd114));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
